// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I decode stage with a DEPTH-entry decoded-instruction queue

`ifndef TYPE_BIT
`define TYPE_BIT 6
`endif

module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter int TYPE_W   = `TYPE_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TYPE_W-1:0]            out_type,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [31:0]                  out_imm,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         out_has_rs1,
  output logic                         out_has_rs2,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Instruction type codes; 0 is reserved for illegal encodings.
  localparam logic [TYPE_W-1:0] T_LUI   = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_AUIPC = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_JAL   = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] T_JALR  = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] T_BEQ   = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] T_BNE   = TYPE_W'(6);
  localparam logic [TYPE_W-1:0] T_BLT   = TYPE_W'(7);
  localparam logic [TYPE_W-1:0] T_BGE   = TYPE_W'(8);
  localparam logic [TYPE_W-1:0] T_BLTU  = TYPE_W'(9);
  localparam logic [TYPE_W-1:0] T_BGEU  = TYPE_W'(10);
  localparam logic [TYPE_W-1:0] T_LB    = TYPE_W'(11);
  localparam logic [TYPE_W-1:0] T_LH    = TYPE_W'(12);
  localparam logic [TYPE_W-1:0] T_LW    = TYPE_W'(13);
  localparam logic [TYPE_W-1:0] T_LBU   = TYPE_W'(14);
  localparam logic [TYPE_W-1:0] T_LHU   = TYPE_W'(15);
  localparam logic [TYPE_W-1:0] T_SB    = TYPE_W'(16);
  localparam logic [TYPE_W-1:0] T_SH    = TYPE_W'(17);
  localparam logic [TYPE_W-1:0] T_SW    = TYPE_W'(18);
  localparam logic [TYPE_W-1:0] T_ADDI  = TYPE_W'(19);
  localparam logic [TYPE_W-1:0] T_SLTI  = TYPE_W'(20);
  localparam logic [TYPE_W-1:0] T_SLTIU = TYPE_W'(21);
  localparam logic [TYPE_W-1:0] T_XORI  = TYPE_W'(22);
  localparam logic [TYPE_W-1:0] T_ORI   = TYPE_W'(23);
  localparam logic [TYPE_W-1:0] T_ANDI  = TYPE_W'(24);
  localparam logic [TYPE_W-1:0] T_SLLI  = TYPE_W'(25);
  localparam logic [TYPE_W-1:0] T_SRLI  = TYPE_W'(26);
  localparam logic [TYPE_W-1:0] T_SRAI  = TYPE_W'(27);
  localparam logic [TYPE_W-1:0] T_ADD   = TYPE_W'(28);
  localparam logic [TYPE_W-1:0] T_SUB   = TYPE_W'(29);
  localparam logic [TYPE_W-1:0] T_SLL   = TYPE_W'(30);
  localparam logic [TYPE_W-1:0] T_SLT   = TYPE_W'(31);
  localparam logic [TYPE_W-1:0] T_SLTU  = TYPE_W'(32);
  localparam logic [TYPE_W-1:0] T_XOR   = TYPE_W'(33);
  localparam logic [TYPE_W-1:0] T_OR    = TYPE_W'(34);
  localparam logic [TYPE_W-1:0] T_AND   = TYPE_W'(35);
  localparam logic [TYPE_W-1:0] T_SRL   = TYPE_W'(36);
  localparam logic [TYPE_W-1:0] T_SRA   = TYPE_W'(37);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded fields of in_inst
  logic [TYPE_W-1:0] w_type;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [31:0]       w_imm;
  logic              w_has_rs1;
  logic              w_has_rs2;
  logic              w_illegal;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [31:0]       w_imm_i;
  logic [31:0]       w_imm_s;
  logic [31:0]       w_imm_b;
  logic [31:0]       w_imm_u;
  logic [31:0]       w_imm_j;
  logic [31:0]       w_imm_sh;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u  = {in_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, in_inst[24:20]};

  // Combinational decode with canonicalisation of unused register fields
  always_comb begin
    w_type    = '0;
    w_rd      = in_inst[11:7];
    w_rs1     = '0;
    w_rs2     = '0;
    w_imm     = '0;
    w_has_rs1 = 1'b0;
    w_has_rs2 = 1'b0;
    w_illegal = 1'b0;

    case (w_opcode)
      OP_LUI: begin
        w_type = T_LUI;
        w_imm  = w_imm_u;
      end
      OP_AUIPC: begin
        w_type = T_AUIPC;
        w_imm  = w_imm_u;
      end
      OP_JAL: begin
        w_type = T_JAL;
        w_imm  = w_imm_j;
      end
      OP_JALR: begin
        w_type    = T_JALR;
        w_imm     = w_imm_i;
        w_has_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        w_rd      = '0;
        w_imm     = w_imm_b;
        w_has_rs1 = 1'b1;
        w_has_rs2 = 1'b1;
        case (w_f3)
          3'b000:  w_type = T_BEQ;
          3'b001:  w_type = T_BNE;
          3'b100:  w_type = T_BLT;
          3'b101:  w_type = T_BGE;
          3'b110:  w_type = T_BLTU;
          3'b111:  w_type = T_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_imm     = w_imm_i;
        w_has_rs1 = 1'b1;
        case (w_f3)
          3'b000:  w_type = T_LB;
          3'b001:  w_type = T_LH;
          3'b010:  w_type = T_LW;
          3'b100:  w_type = T_LBU;
          3'b101:  w_type = T_LHU;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_rd      = '0;
        w_imm     = w_imm_s;
        w_has_rs1 = 1'b1;
        w_has_rs2 = 1'b1;
        case (w_f3)
          3'b000:  w_type = T_SB;
          3'b001:  w_type = T_SH;
          3'b010:  w_type = T_SW;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ALUI: begin
        w_imm     = w_imm_i;
        w_has_rs1 = 1'b1;
        case (w_f3)
          3'b000: w_type = T_ADDI;
          3'b010: w_type = T_SLTI;
          3'b011: w_type = T_SLTIU;
          3'b100: w_type = T_XORI;
          3'b110: w_type = T_ORI;
          3'b111: w_type = T_ANDI;
          3'b001: begin
            w_imm = w_imm_sh;
            if (w_f7 == F7_BASE) w_type = T_SLLI;
            else                 w_illegal = 1'b1;
          end
          default: begin
            w_imm = w_imm_sh;
            if (w_f7 == F7_BASE)     w_type = T_SRLI;
            else if (w_f7 == F7_ALT) w_type = T_SRAI;
            else                     w_illegal = 1'b1;
          end
        endcase
      end
      OP_ALUR: begin
        w_has_rs1 = 1'b1;
        w_has_rs2 = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b000:  w_type = T_ADD;
            3'b001:  w_type = T_SLL;
            3'b010:  w_type = T_SLT;
            3'b011:  w_type = T_SLTU;
            3'b100:  w_type = T_XOR;
            3'b101:  w_type = T_SRL;
            3'b110:  w_type = T_OR;
            default: w_type = T_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_type = T_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_type = T_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase

    // Compressed/reserved quadrants; normally already caught by the opcode match.
    if (in_inst[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end

    if (w_illegal) begin
      w_type    = '0;
      w_imm     = '0;
      w_rd      = '0;
      w_has_rs1 = 1'b0;
      w_has_rs2 = 1'b0;
    end

    // Unread source fields are forced to zero so issue never sees stale indices.
    w_rs1 = w_has_rs1 ? in_inst[19:15] : 5'd0;
    w_rs2 = w_has_rs2 ? in_inst[24:20] : 5'd0;
  end

  // Queue storage and control
  logic [TYPE_W-1:0]   r_type_mem    [DEPTH];
  logic [4:0]          r_rs1_mem     [DEPTH];
  logic [4:0]          r_rs2_mem     [DEPTH];
  logic [4:0]          r_rd_mem      [DEPTH];
  logic [31:0]         r_imm_mem     [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem      [DEPTH];
  logic                r_has_rs1_mem [DEPTH];
  logic                r_has_rs2_mem [DEPTH];
  logic                r_illegal_mem [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count_out = r_count;

  // Pointer and occupancy update; flush overrides any same-cycle push or pop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Store the decoded entry into the tail slot on an accepted push
  always_ff @(posedge clk_in) begin
    if (w_push && !flush_in) begin
      r_type_mem[r_wptr]    <= w_type;
      r_rs1_mem[r_wptr]     <= w_rs1;
      r_rs2_mem[r_wptr]     <= w_rs2;
      r_rd_mem[r_wptr]      <= w_rd;
      r_imm_mem[r_wptr]     <= w_imm;
      r_pc_mem[r_wptr]      <= in_pc;
      r_has_rs1_mem[r_wptr] <= w_has_rs1;
      r_has_rs2_mem[r_wptr] <= w_has_rs2;
      r_illegal_mem[r_wptr] <= w_illegal;
    end
  end

  assign out_type    = r_type_mem[r_rptr];
  assign out_rs1     = r_rs1_mem[r_rptr];
  assign out_rs2     = r_rs2_mem[r_rptr];
  assign out_rd      = r_rd_mem[r_rptr];
  assign out_imm     = r_imm_mem[r_rptr];
  assign out_pc      = r_pc_mem[r_rptr];
  assign out_has_rs1 = r_has_rs1_mem[r_rptr];
  assign out_has_rs2 = r_has_rs2_mem[r_rptr];
  assign out_illegal = r_illegal_mem[r_rptr];

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue

module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int TW    = 6;

  localparam logic [31:0] T_LUI  = 32'd1;
  localparam logic [31:0] T_BEQ  = 32'd5;
  localparam logic [31:0] T_SW   = 32'd18;
  localparam logic [31:0] T_ADDI = 32'd19;
  localparam logic [31:0] T_SRAI = 32'd27;
  localparam logic [31:0] T_ADD  = 32'd28;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           flush_in;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_inst;
  logic [PCW-1:0] in_pc;
  logic           out_valid;
  logic           out_ready;
  logic [TW-1:0]  out_type;
  logic [4:0]     out_rs1;
  logic [4:0]     out_rs2;
  logic [4:0]     out_rd;
  logic [31:0]    out_imm;
  logic [PCW-1:0] out_pc;
  logic           out_has_rs1;
  logic           out_has_rs2;
  logic           out_illegal;
  logic [2:0]     count_out;

  int n_total = 0;
  int n_bad   = 0;

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .TYPE_W(TW)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_has_rs1 (out_has_rs1),
    .out_has_rs2 (out_has_rs2),
    .out_illegal (out_illegal),
    .count_out   (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] typ, input logic [31:0] rd,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [31:0] hr1, input logic [31:0] hr2,
                          input logic [31:0] ill);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_type"}, 32'(out_type), typ);
    check({tag, "_rd"}, 32'(out_rd), rd);
    check({tag, "_rs1"}, 32'(out_rs1), rs1);
    check({tag, "_rs2"}, 32'(out_rs2), rs2);
    check({tag, "_imm"}, out_imm, imm);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_hrs1"}, 32'(out_has_rs1), hr1);
    check({tag, "_hrs2"}, 32'(out_has_rs2), hr2);
    check({tag, "_ill"}, 32'(out_illegal), ill);
  endtask

  function automatic logic [31:0] addi_x(input int r);
    return (32'(r) << 20) | (32'(r) << 7) | 32'h13;
  endfunction

  initial begin
    rst_in    = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #12;
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_in = 1'b0;
    step();

    // ADDI x5,x0,-1 single push
    push_one(32'hFFF00293, 32'h100);
    check("addi_count", 32'(count_out), 32'd1);
    chk_head("addi", T_ADDI, 5, 0, 0, 32'hFFFFFFFF, 32'h100, 1, 0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("addi_drained", 32'(count_out), 32'd0);

    // Fill past capacity with the consumer stalled
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_inst  = addi_x(i);
      in_pc    = 32'h200 + 32'(4 * i);
      check($sformatf("fill_ready%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    check("fill_count", 32'(count_out), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_head($sformatf("drain%0d", i), T_ADDI, 32'(i), 0, 0, 32'(i), 32'h200 + 32'(4 * i), 1, 0, 0);
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count_out), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Full with push attempt and pop together: only the pop happens
    for (int i = 11; i <= 14; i++) push_one(addi_x(i), 32'h300 + 32'(i));
    in_valid  = 1'b1;
    in_inst   = addi_x(15);
    in_pc     = 32'h300 + 32'd15;
    out_ready = 1'b1;
    check("full_ready", 32'(in_ready), 32'd0);
    step();
    check("full_pop_count", 32'(count_out), 32'd3);
    check("full_pop_head", 32'(out_rd), 32'd12);
    in_valid = 1'b0;
    step();
    check("half_count", 32'(count_out), 32'd2);
    check("half_head", 32'(out_rd), 32'd13);
    in_valid = 1'b1;
    check("half_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("pushpop_count", 32'(count_out), 32'd2);
    chk_head("pp14", T_ADDI, 14, 0, 0, 14, 32'h300 + 32'd14, 1, 0, 0);
    step();
    chk_head("pp15", T_ADDI, 15, 0, 0, 15, 32'h300 + 32'd15, 1, 0, 0);
    step();
    out_ready = 1'b0;
    check("pp_empty", 32'(count_out), 32'd0);

    // Immediate formats: SW, two BEQ offsets, LUI
    push_one(32'h00712423, 32'h400);
    push_one(32'hFE000EE3, 32'h404);
    push_one(32'hFE000E63, 32'h408);
    push_one(32'h12345537, 32'h40C);
    out_ready = 1'b1;
    chk_head("sw", T_SW, 0, 2, 7, 8, 32'h400, 1, 1, 0);
    step();
    chk_head("beq_a", T_BEQ, 0, 0, 0, 32'hFFFFFFFC, 32'h404, 1, 1, 0);
    step();
    chk_head("beq_b", T_BEQ, 0, 0, 0, 32'hFFFFF7FC, 32'h408, 1, 1, 0);
    step();
    chk_head("lui", T_LUI, 10, 0, 0, 32'h12345000, 32'h40C, 0, 0, 0);
    step();
    out_ready = 1'b0;

    // Illegal encodings stay in program order between legal ones
    push_one(32'h002081B3, 32'h500);
    push_one(32'h0000007F, 32'h504);
    push_one(32'h20335293, 32'h508);
    push_one(32'h40335293, 32'h50C);
    out_ready = 1'b1;
    chk_head("add", T_ADD, 3, 1, 2, 0, 32'h500, 1, 1, 0);
    step();
    chk_head("ill_op", 0, 0, 0, 0, 0, 32'h504, 0, 0, 1);
    step();
    chk_head("ill_srai", 0, 0, 0, 0, 0, 32'h508, 0, 0, 1);
    step();
    chk_head("srai", T_SRAI, 5, 6, 0, 3, 32'h50C, 1, 0, 0);
    step();
    out_ready = 1'b0;

    // Flush with a simultaneous push
    for (int i = 1; i <= 3; i++) push_one(addi_x(i), 32'h600 + 32'(i));
    check("preflush_count", 32'(count_out), 32'd3);
    flush_in = 1'b1;
    in_valid = 1'b1;
    in_inst  = addi_x(20);
    in_pc    = 32'h6FF;
    step();
    flush_in = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count_out), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    push_one(addi_x(21), 32'h700);
    check("postflush_count", 32'(count_out), 32'd1);
    check("postflush_pc", out_pc, 32'h700);
    check("postflush_rd", 32'(out_rd), 32'd21);

    // Asynchronous reset between edges
    push_one(addi_x(22), 32'h704);
    check("prerst_count", 32'(count_out), 32'd2);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_count", 32'(count_out), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    #1;
    rst_in = 1'b0;
    step();
    check("postrst_count", 32'(count_out), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
